tcdm_xbar_pipe: RTL and testbench

- Parametrised NumIn x NumOut TCDM logarithmic crossbar with per-bank round-robin arbitration.
- Adds an optional registered request stage, configurable bank read latency via a per-bank response tag pipeline, and selectable write responses.
- Sits between cluster initiators (cores, DMA) and single-ported SRAM banks.
- Successor to the flat lic node for configs whose timing needs a cut on the bank-side request path.

---
 rtl/tcdm_xbar_pipe.sv | 198 +++++++++++++++++++
 tb/tb_tcdm_xbar_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_xbar_pipe.sv
// NumIn x NumOut TCDM crossbar: per-bank round-robin, optional request register, tagged response pipe.
// Latency gnt_o->vld_o = MemLatency (+1 with ReqRegOn); a stalled bank (gnt_i=0) holds its request and withholds gnt_o.
module tcdm_xbar_pipe #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned NumOut       = 8,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned WriteRespOn  = 1,
  parameter int unsigned ReqRegOn     = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]       add_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]         be_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]       rdata_o,
  output logic [NumOut-1:0]                     req_o,
  input  logic [NumOut-1:0]                     gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0]   add_o,
  output logic [NumOut-1:0]                     wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]      wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]        be_o,
  input  logic [NumOut-1:0][DataWidth-1:0]      rdata_i
);
  localparam int unsigned WordOff = $clog2(BeWidth);
  localparam int unsigned BankW   = $clog2(NumOut);
  localparam int unsigned InW     = $clog2(NumIn);

  logic [NumIn-1:0][BankW-1:0]         w_bank;
  logic [NumIn-1:0][AddrMemWidth-1:0]  w_waddr;
  logic                                w_unused_addr;

  always_comb begin
    for (int j = 0; j < NumIn; j++) begin
      w_bank[j]  = add_i[j][WordOff +: BankW];
      w_waddr[j] = add_i[j][WordOff+BankW +: AddrMemWidth];
    end
  end
  assign w_unused_addr = ^add_i;

  logic [NumOut-1:0][InW-1:0] r_rr, w_win;
  logic [NumOut-1:0]          w_any, w_acc;
  logic [InW-1:0]             w_c;

  // Winner is the first requester at or above the pointer, wrapping.
  always_comb begin
    w_any = '0;
    w_win = '0;
    w_c   = '0;
    for (int k = 0; k < NumOut; k++) begin
      for (int o = 0; o < NumIn; o++) begin
        w_c = r_rr[k] + InW'(o);
        if (!w_any[k] && req_i[w_c] && (w_bank[w_c] == BankW'(k))) begin
          w_any[k] = 1'b1;
          w_win[k] = w_c;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else begin
      for (int k = 0; k < NumOut; k++)
        if (w_acc[k]) r_rr[k] <= w_win[k] + InW'(1);
    end
  end

  logic [NumOut-1:0]                   w_req, w_wen;
  logic [NumOut-1:0][AddrMemWidth-1:0] w_add;
  logic [NumOut-1:0][DataWidth-1:0]    w_wdata;
  logic [NumOut-1:0][BeWidth-1:0]      w_be;
  logic [NumOut-1:0][InW-1:0]          w_didx;

  if (ReqRegOn == 0) begin : g_comb
    always_comb begin
      for (int k = 0; k < NumOut; k++) begin
        w_req[k]   = w_any[k];
        w_acc[k]   = w_any[k] & gnt_i[k];
        w_didx[k]  = w_win[k];
        w_add[k]   = w_any[k] ? w_waddr[w_win[k]] : '0;
        w_wen[k]   = w_any[k] & wen_i[w_win[k]];
        w_wdata[k] = w_any[k] ? wdata_i[w_win[k]] : '0;
        w_be[k]    = w_any[k] ? be_i[w_win[k]] : '0;
      end
    end
  end else begin : g_reg
    logic [NumOut-1:0]                   r_full, r_wen;
    logic [NumOut-1:0][AddrMemWidth-1:0] r_add;
    logic [NumOut-1:0][DataWidth-1:0]    r_wdata;
    logic [NumOut-1:0][BeWidth-1:0]      r_be;
    logic [NumOut-1:0][InW-1:0]          r_idx;

    always_comb begin
      for (int k = 0; k < NumOut; k++)
        w_acc[k] = w_any[k] & (!r_full[k] | gnt_i[k]);
    end

    // A full slot drains on gnt_i and may refill in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_full  <= '0;
        r_wen   <= '0;
        r_add   <= '0;
        r_wdata <= '0;
        r_be    <= '0;
        r_idx   <= '0;
      end else begin
        for (int k = 0; k < NumOut; k++) begin
          if (w_acc[k]) begin
            r_full[k]  <= 1'b1;
            r_wen[k]   <= wen_i[w_win[k]];
            r_add[k]   <= w_waddr[w_win[k]];
            r_wdata[k] <= wdata_i[w_win[k]];
            r_be[k]    <= be_i[w_win[k]];
            r_idx[k]   <= w_win[k];
          end else if (gnt_i[k]) begin
            r_full[k] <= 1'b0;
          end
        end
      end
    end

    assign w_req   = r_full;
    assign w_wen   = r_wen;
    assign w_add   = r_add;
    assign w_wdata = r_wdata;
    assign w_be    = r_be;
    assign w_didx  = r_idx;
  end

  logic [NumIn-1:0] w_gnt;
  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < NumOut; k++)
      if (w_acc[k]) w_gnt[w_win[k]] = 1'b1;
  end

  assign gnt_o   = rst_i ? '0 : w_gnt;
  assign req_o   = rst_i ? '0 : w_req;
  assign add_o   = rst_i ? '0 : w_add;
  assign wen_o   = rst_i ? '0 : w_wen;
  assign wdata_o = rst_i ? '0 : w_wdata;
  assign be_o    = rst_i ? '0 : w_be;

  logic [NumOut-1:0][MemLatency-1:0]          r_tv;
  logic [NumOut-1:0][MemLatency-1:0][InW-1:0] r_ti;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tv <= '0;
      r_ti <= '0;
    end else begin
      for (int k = 0; k < NumOut; k++) begin
        r_tv[k][0] <= w_req[k] & gnt_i[k] & (!w_wen[k] | (WriteRespOn != 0));
        r_ti[k][0] <= w_didx[k];
        for (int s = 1; s < MemLatency; s++) begin
          r_tv[k][s] <= r_tv[k][s-1];
          r_ti[k][s] <= r_ti[k][s-1];
        end
      end
    end
  end

  logic [NumIn-1:0]                w_vld;
  logic [NumIn-1:0][DataWidth-1:0] w_rdata;
  logic                            w_dup;

  always_comb begin
    w_vld   = '0;
    w_rdata = '0;
    w_dup   = 1'b0;
    for (int k = 0; k < NumOut; k++) begin
      if (r_tv[k][MemLatency-1]) begin
        if (w_vld[r_ti[k][MemLatency-1]]) w_dup = 1'b1;
        w_vld[r_ti[k][MemLatency-1]]   = 1'b1;
        w_rdata[r_ti[k][MemLatency-1]] = rdata_i[k];
      end
    end
  end

  assign vld_o   = w_vld;
  assign rdata_o = w_rdata;

  a_params: assert property (@(posedge clk_i)
    ((NumIn & (NumIn - 1)) == 0) && ((NumOut & (NumOut - 1)) == 0) &&
    (AddrWidth >= WordOff + BankW + AddrMemWidth) && (MemLatency >= 1));
  a_one_resp: assert property (@(posedge clk_i) disable iff (rst_i) !w_dup);

endmodule

// File: tb/tb_tcdm_xbar_pipe.sv
// Scoreboard bench for tcdm_xbar_pipe across three configurations:
// g0 = comb/lat1/wresp, g1 = reg/lat2/wresp, g2 = reg/lat3/no-wresp.
module tb_tcdm_xbar_pipe;
  localparam int NI = 4, NO = 8, AW = 32, DW = 32, BW = 4, AMW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   rst     [3];
  logic [NI-1:0]          req     [3];
  logic [NI-1:0]          wen     [3];
  logic [NI-1:0]          gnt_o   [3];
  logic [NI-1:0]          vld_o   [3];
  logic [NI-1:0][AW-1:0]  add     [3];
  logic [NI-1:0][DW-1:0]  wdata   [3];
  logic [NI-1:0][DW-1:0]  rdata_o [3];
  logic [NI-1:0][BW-1:0]  be      [3];
  logic [NO-1:0]          req_o   [3];
  logic [NO-1:0]          gnt_i   [3];
  logic [NO-1:0]          wen_o   [3];
  logic [NO-1:0][AMW-1:0] add_o   [3];
  logic [NO-1:0][DW-1:0]  wdata_o [3];
  logic [NO-1:0][DW-1:0]  rdata_i [3];
  logic [NO-1:0][BW-1:0]  be_o    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tcdm_xbar_pipe #(
      .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
      .AddrMemWidth(AMW), .MemLatency(g + 1), .WriteRespOn(g < 2 ? 1 : 0),
      .ReqRegOn(g > 0 ? 1 : 0)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .req_i(req[g]), .add_i(add[g]), .wen_i(wen[g]),
      .wdata_i(wdata[g]), .be_i(be[g]), .gnt_o(gnt_o[g]), .vld_o(vld_o[g]),
      .rdata_o(rdata_o[g]), .req_o(req_o[g]), .gnt_i(gnt_i[g]), .add_o(add_o[g]),
      .wen_o(wen_o[g]), .wdata_o(wdata_o[g]), .be_o(be_o[g]), .rdata_i(rdata_i[g])
    );
  end

  // kind: 0 gnt_o, 1 vld_o, 2 bank handshake, 3 reset-zero probe, 4 stalled-bank probe
  typedef struct {
    int          g;
    int          kind;
    int          idx;
    int          cyc;
    logic [31:0] dat;
    logic [31:0] dat2;
    bit          chk;
  } exp_t;
  exp_t sbq[$];
  int n_vec = 0, n_err = 0;

  function automatic logic [31:0] hs(logic w, logic [3:0] b, logic [11:0] a);
    return {15'd0, w, b, a};
  endfunction

  function automatic string kname(int kind);
    return (kind == 0) ? "gnt_o" : (kind == 1) ? "vld_o" : "bank_req";
  endfunction

  task automatic push(int g, int kind, int idx, int c, logic [31:0] dat, logic [31:0] dat2, bit chk);
    exp_t e;
    e.g = g; e.kind = kind; e.idx = idx; e.cyc = c; e.dat = dat; e.dat2 = dat2; e.chk = chk;
    sbq.push_back(e);
  endtask

  task automatic check(string name, int g, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s g%0d cyc %0d: got %0h, required %0h", name, g, cyc, act, want);
    end
  endtask

  task automatic observe(int g, int kind, int idx, logic [31:0] dat, logic [31:0] dat2);
    int f = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (f < 0 && sbq[i].g == g && sbq[i].kind == kind && sbq[i].idx == idx && sbq[i].cyc == cyc)
        f = i;
    if (f < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected %s g%0d idx%0d cyc %0d: got event, required none", kname(kind), g, idx, cyc);
    end else begin
      if (sbq[f].chk) begin
        check({kname(kind), "_data"}, g, dat, sbq[f].dat);
        if (kind == 2) check("bank_wdata", g, dat2, sbq[f].dat2);
      end else begin
        n_vec++;
      end
      sbq.delete(f);
    end
  endtask

  task automatic probe(exp_t e);
    int g = e.g;
    if (e.kind == 3) begin
      check("rst_gnt_o",   g, 32'(gnt_o[g]), 0);
      check("rst_vld_o",   g, 32'(vld_o[g]), 0);
      check("rst_rdata_o", g, 32'(|rdata_o[g]), 0);
      check("rst_req_o",   g, 32'(req_o[g]), 0);
      check("rst_add_o",   g, 32'(|add_o[g]), 0);
      check("rst_wen_o",   g, 32'(wen_o[g]), 0);
      check("rst_wdata_o", g, 32'(|wdata_o[g]), 0);
      check("rst_be_o",    g, 32'(|be_o[g]), 0);
    end else begin
      check("stall_req_o",  g, 32'(req_o[g][e.idx]), 1);
      check("stall_fields", g, hs(wen_o[g][e.idx], be_o[g][e.idx], add_o[g][e.idx]), e.dat);
      check("stall_wdata",  g, wdata_o[g][e.idx], e.dat2);
    end
  endtask

  // Monitor: match every observed event against the queue, then retire overdue entries.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        for (int j = 0; j < NI; j++) begin
          if (gnt_o[g][j]) observe(g, 0, j, 0, 0);
          if (vld_o[g][j]) observe(g, 1, j, rdata_o[g][j], 0);
          else check("idle_rdata_o", g, rdata_o[g][j], 0);
        end
        for (int k = 0; k < NO; k++)
          if (req_o[g][k] && gnt_i[g][k])
            observe(g, 2, k, hs(wen_o[g][k], be_o[g][k], add_o[g][k]), wdata_o[g][k]);
      end
      for (int i = sbq.size() - 1; i >= 0; i--)
        if (sbq[i].kind >= 3 && sbq[i].cyc == cyc) begin
          probe(sbq[i]);
          sbq.delete(i);
        end
      for (int i = sbq.size() - 1; i >= 0; i--)
        if (sbq[i].cyc <= cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL missing %s g%0d idx%0d: got none by cyc %0d, required at cyc %0d",
                   kname(sbq[i].kind), sbq[i].g, sbq[i].idx, cyc, sbq[i].cyc);
          sbq.delete(i);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int g, int j, logic [31:0] a, logic w, logic [3:0] b, logic [31:0] d);
    req[g][j] = 1'b1; add[g][j] = a; wen[g][j] = w; be[g][j] = b; wdata[g][j] = d;
  endtask

  task automatic idle(int g, int j);
    req[g][j] = 1'b0;
  endtask

  int t;

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; req[g] = '0; add[g] = '0; wen[g] = '0; wdata[g] = '0; be[g] = '0;
      gnt_i[g] = '1;
      for (int k = 0; k < NO; k++) rdata_i[g][k] = 32'hCAFE0000 + 32'(k);
      for (int j = 0; j < NI; j++) drive(g, j, 32'h104, 1'b0, 4'hF, 32'h0);
    end

    // Reset: outputs must be zero even with live requests on the inputs.
    tick();
    for (int g = 0; g < 3; g++) push(g, 3, 0, cyc, 0, 0, 0);
    tick();
    for (int g = 0; g < 3; g++) begin rst[g] = 1'b0; req[g] = '0; end

    // g0: single load to bank 1, word 0x008.
    tick(); t = cyc;
    drive(0, 0, 32'h104, 1'b0, 4'hF, 32'h0);
    push(0, 0, 0, t, 0, 0, 0);
    push(0, 2, 1, t, hs(1'b0, 4'hF, 12'h008), 32'h0, 1);
    push(0, 1, 0, t + 1, 32'hCAFE0001, 0, 1);
    tick(); idle(0, 0);
    tick();

    // g0: all initiators hammer bank 3; grants rotate 0,1,2,3,0.
    tick(); t = cyc;
    for (int j = 0; j < NI; j++) drive(0, j, 32'(j * 32 + 12), 1'b0, 4'hF, 32'(j));
    for (int i = 0; i < 5; i++) begin
      push(0, 0, i % 4, t + i, 0, 0, 0);
      push(0, 2, 3, t + i, hs(1'b0, 4'hF, 12'(i % 4)), 32'(i % 4), 1);
      push(0, 1, i % 4, t + i + 1, 32'hCAFE0003, 0, 1);
    end
    repeat (5) tick();
    req[0] = '0;
    tick();

    // g1 (write responses) and g2 (none): initiator 2 stores be=0x3 to bank 5, word 0x021.
    tick(); t = cyc;
    for (int g = 1; g < 3; g++) begin
      drive(g, 2, 32'h434, 1'b1, 4'h3, 32'h5A5A0002);
      push(g, 0, 2, t, 0, 0, 0);
      push(g, 2, 5, t + 1, hs(1'b1, 4'h3, 12'h021), 32'h5A5A0002, 1);
    end
    push(1, 1, 2, t + 3, 0, 0, 0);
    tick(); idle(1, 2); idle(2, 2);
    repeat (4) tick();

    // g1: bank 0 stalled for 3 cycles with initiators 1 and 3 contending.
    tick(); t = cyc;
    gnt_i[1][0] = 1'b0;
    drive(1, 1, 32'h220, 1'b0, 4'hF, 32'h11110001);
    drive(1, 3, 32'h660, 1'b0, 4'hF, 32'h33330003);
    push(1, 0, 1, t, 0, 0, 0);
    push(1, 4, 0, t + 1, hs(1'b0, 4'hF, 12'h011), 32'h11110001, 0);
    push(1, 4, 0, t + 2, hs(1'b0, 4'hF, 12'h011), 32'h11110001, 0);
    push(1, 2, 0, t + 3, hs(1'b0, 4'hF, 12'h011), 32'h11110001, 1);
    push(1, 0, 3, t + 3, 0, 0, 0);
    push(1, 2, 0, t + 4, hs(1'b0, 4'hF, 12'h033), 32'h33330003, 1);
    push(1, 1, 1, t + 5, 32'hCAFE0000, 0, 1);
    push(1, 1, 3, t + 6, 32'hCAFE0000, 0, 1);
    tick(); idle(1, 1);
    tick();
    tick(); gnt_i[1][0] = 1'b1;
    tick(); idle(1, 3);
    repeat (4) tick();

    // g2: three loads in flight, then a reset pulse drops them all.
    tick(); t = cyc;
    drive(2, 0, 32'h28, 1'b0, 4'hF, 32'h0);
    drive(2, 1, 32'h50, 1'b0, 4'hF, 32'h0);
    drive(2, 2, 32'h78, 1'b0, 4'hF, 32'h0);
    for (int j = 0; j < 3; j++) begin
      push(2, 0, j, t, 0, 0, 0);
      push(2, 2, 2 * j + 2, t + 1, hs(1'b0, 4'hF, 12'(j + 1)), 32'h0, 1);
    end
    tick(); req[2] = '0;
    tick(); rst[2] = 1'b1;
    drive(2, 0, 32'h28, 1'b0, 4'hF, 32'h0);
    push(2, 3, 0, cyc, 0, 0, 0);
    tick(); push(2, 3, 0, cyc, 0, 0, 0);
    tick(); rst[2] = 1'b0; idle(2, 0);
    repeat (5) tick();

    // g2: pointer of bank 2 must restart at initiator 0 after reset.
    tick(); t = cyc;
    drive(2, 0, 32'h28, 1'b0, 4'hF, 32'h000000A0);
    drive(2, 3, 32'hE8, 1'b0, 4'hF, 32'h000000A3);
    push(2, 0, 0, t, 0, 0, 0);
    push(2, 0, 3, t + 1, 0, 0, 0);
    push(2, 2, 2, t + 1, hs(1'b0, 4'hF, 12'h001), 32'h000000A0, 1);
    push(2, 2, 2, t + 2, hs(1'b0, 4'hF, 12'h007), 32'h000000A3, 1);
    push(2, 1, 0, t + 4, 32'hCAFE0002, 0, 1);
    push(2, 1, 3, t + 5, 32'hCAFE0002, 0, 1);
    tick(); idle(2, 0);
    tick(); idle(2, 3);
    repeat (8) tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
